// File: rtl/player_pkg.sv
// Shared encodings and default physics constants for the dino vertical-motion engine.
package player_pkg;

   typedef enum logic [1:0] {
      ST_GROUND   = 2'd0,
      ST_RISE     = 2'd1,
      ST_FALL     = 2'd2,
      ST_FASTDROP = 2'd3
   } motion_st_t;

   localparam int DEF_POS_W             = 6;
   localparam int DEF_VEL_W             = 4;
   localparam int DEF_JUMP_VELOCITY     = -7;
   localparam int DEF_GRAVITY           = 1;
   localparam int DEF_FASTDROP_VELOCITY = 6;
   localparam int DEF_MAX_FALL_VELOCITY = 6;
   localparam int DEF_HOLD_TICKS        = 4;

endpackage

// File: rtl/player_motion_ctrl_sat_add.sv
// Signed saturating adder: clamps to the W-bit signed range instead of wrapping.
// Purely combinational; no handshake.
module sat_add_s #(
   parameter int W = 8
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum
);

   logic signed [W:0] full;

   assign full = {a[W-1], a} + {b[W-1], b};

   // Sign bits of the extended sum disagree only on overflow.
   always_comb begin
      sum = full[W-1:0];
      if (full[W] != full[W-1]) begin
         sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/player_motion_ctrl.sv
// Dino vertical-motion engine: two-phase tick physics, held jump, fast drop; outputs registered, 1-cycle latency.
// No backpressure (strobes always accepted); DOUBLE_JUMP_EN adds one mid-air jump per airtime.
module player_motion_ctrl
   import player_pkg::*;
#(
   parameter int POS_W             = DEF_POS_W,
   parameter int VEL_W             = DEF_VEL_W,
   parameter int JUMP_VELOCITY     = DEF_JUMP_VELOCITY,
   parameter int GRAVITY           = DEF_GRAVITY,
   parameter int FASTDROP_VELOCITY = DEF_FASTDROP_VELOCITY,
   parameter int MAX_FALL_VELOCITY = DEF_MAX_FALL_VELOCITY,
   parameter int HOLD_TICKS        = DEF_HOLD_TICKS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    vel_tick,
   input  logic                    pos_tick,
   input  logic                    jump_btn,
   input  logic                    down_btn,
   output logic signed [POS_W-1:0] position,
   output logic signed [VEL_W-1:0] velocity,
   output logic [1:0]              state,
   output logic                    duck,
   output logic                    land_pulse
);

   localparam int HC_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
   localparam logic signed [VEL_W-1:0] JUMP_V     = VEL_W'(JUMP_VELOCITY);
   localparam logic signed [VEL_W-1:0] GRAV_V     = VEL_W'(GRAVITY);
   localparam logic signed [VEL_W-1:0] FDROP_V    = VEL_W'(FASTDROP_VELOCITY);
   localparam logic signed [VEL_W-1:0] MAX_FALL_V = VEL_W'(MAX_FALL_VELOCITY);
   localparam logic [HC_W-1:0]         HOLD_MAX   = HC_W'(HOLD_TICKS);

   motion_st_t              state_q, state_nx;
   logic signed [POS_W-1:0] pos_nx, pos_sum, vel_ext;
   logic signed [VEL_W-1:0] vel_nx, vel_sum, vel_grav;
   logic [HC_W-1:0]         hold_cnt, hold_nx;
   logic                    jump_pend, pend_nx, jump_btn_q, land_nx;
   logic                    airborne, jump_edge, air_jump_ok;

   assign state     = state_q;
   assign airborne  = (state_q != ST_GROUND);
   assign jump_edge = jump_btn & ~jump_btn_q;
   assign vel_ext   = POS_W'(velocity);
   assign vel_grav  = (vel_sum > MAX_FALL_V) ? MAX_FALL_V : vel_sum;

   sat_add_s #(.W(VEL_W)) u_vel_add (.a(velocity), .b(GRAV_V),  .sum(vel_sum));
   sat_add_s #(.W(POS_W)) u_pos_add (.a(position), .b(vel_ext), .sum(pos_sum));

`ifdef DOUBLE_JUMP_EN
   logic dj_avail;

   assign air_jump_ok = dj_avail && (state_q == ST_RISE || state_q == ST_FALL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dj_avail <= 1'b1;
      end else if (land_nx) begin
         dj_avail <= 1'b1;
      end else if (vel_tick && jump_pend && !down_btn &&
                   (state_q == ST_RISE || state_q == ST_FALL)) begin
         dj_avail <= 1'b0;
      end
   end
`else
   assign air_jump_ok = 1'b0;
`endif

   always_comb begin
      state_nx = state_q;
      vel_nx   = velocity;
      pos_nx   = position;
      hold_nx  = hold_cnt;
      pend_nx  = jump_pend;
      land_nx  = 1'b0;

      // A pending jump lives until the next vel_tick; down on the ground cancels it.
      if (vel_tick) pend_nx = 1'b0;
      if (jump_edge && (!airborne || air_jump_ok)) pend_nx = 1'b1;
      if (!airborne && down_btn) pend_nx = 1'b0;

      if (vel_tick) begin
         case (state_q)
            ST_GROUND: begin
               if (jump_pend && !down_btn) begin
                  vel_nx   = JUMP_V;
                  state_nx = ST_RISE;
                  hold_nx  = '0;
               end
            end
            ST_RISE, ST_FALL: begin
               if (down_btn) begin
                  vel_nx   = FDROP_V;
                  state_nx = ST_FASTDROP;
               end else if (jump_pend) begin
                  vel_nx   = JUMP_V;
                  state_nx = ST_RISE;
                  hold_nx  = '0;
               end else if (state_q == ST_RISE && jump_btn && hold_cnt < HOLD_MAX) begin
                  hold_nx = hold_cnt + 1'b1;
               end else begin
                  // Pinning the counter at max stops a re-press from extending this jump.
                  vel_nx  = vel_grav;
                  hold_nx = HOLD_MAX;
                  if (!vel_grav[VEL_W-1]) state_nx = ST_FALL;
               end
            end
            default: ;
         endcase
      end

      // Position uses the pre-update velocity; landing wins over any velocity update.
      if (pos_tick && airborne) begin
         if (!pos_sum[POS_W-1]) begin
            pos_nx   = '0;
            vel_nx   = '0;
            state_nx = ST_GROUND;
            pend_nx  = 1'b0;
            land_nx  = 1'b1;
         end else begin
            pos_nx = pos_sum;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         position   <= '0;
         velocity   <= '0;
         state_q    <= ST_GROUND;
         hold_cnt   <= '0;
         jump_pend  <= 1'b0;
         jump_btn_q <= 1'b0;
         land_pulse <= 1'b0;
         duck       <= 1'b0;
      end else begin
         position   <= pos_nx;
         velocity   <= vel_nx;
         state_q    <= state_nx;
         hold_cnt   <= hold_nx;
         jump_pend  <= pend_nx;
         jump_btn_q <= jump_btn;
         land_pulse <= land_nx;
         duck       <= (state_q == ST_GROUND) && down_btn;
      end
   end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: scoreboard of expected motion states per step.
module tb_player_motion_ctrl;

   logic clk, rst, rst4;
   logic vel_tick, pos_tick, jump_btn, down_btn;
   logic signed [5:0] position;
   logic signed [3:0] velocity;
   logic [1:0]        state;
   logic              duck, land_pulse;
   logic signed [3:0] position4;
   logic signed [3:0] velocity4;
   logic [1:0]        state4;
   logic              duck4, land_pulse4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string tag;
      int    p;
      int    v;
      int    s;
      int    lp;
   } exp_t;
   exp_t sb[$];

   localparam int G = 0, R = 1, F = 2, D = 3;

   player_motion_ctrl dut (
      .clk(clk), .reset(rst), .vel_tick(vel_tick), .pos_tick(pos_tick),
      .jump_btn(jump_btn), .down_btn(down_btn), .position(position),
      .velocity(velocity), .state(state), .duck(duck), .land_pulse(land_pulse)
   );

   player_motion_ctrl #(.POS_W(4)) dut4 (
      .clk(clk), .reset(rst4), .vel_tick(vel_tick), .pos_tick(pos_tick),
      .jump_btn(jump_btn), .down_btn(down_btn), .position(position4),
      .velocity(velocity4), .state(state4), .duck(duck4), .land_pulse(land_pulse4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input bit vt, input bit pt, input bit jb, input bit db,
                       input int ep, input int ev, input int es, input int elp);
      exp_t e_in, e;
      e_in.tag = tag; e_in.p = ep; e_in.v = ev; e_in.s = es; e_in.lp = elp;
      sb.push_back(e_in);
      vel_tick = vt; pos_tick = pt; jump_btn = jb; down_btn = db;
      @(posedge clk); #1;
      vel_tick = 1'b0; pos_tick = 1'b0;
      e = sb.pop_front();
      chk({e.tag, "_pos"}, int'(position), e.p);
      chk({e.tag, "_vel"}, int'(velocity), e.v);
      chk({e.tag, "_st"},  int'(state),    e.s);
      chk({e.tag, "_lp"},  int'(land_pulse), e.lp);
   endtask

   // Held jump, both strobes each cycle: default width and POS_W=4 copy.
   int t2p[21]  = '{0,-7,-14,-21,-28,-32,-32,-32,-32,-32,-32,-32,-32,-31,-29,-26,-22,-17,-11,-5,0};
   int t2v[21]  = '{-7,-7,-7,-7,-7,-6,-5,-4,-3,-2,-1,0,1,2,3,4,5,6,6,6,0};
   int t2p4[21] = '{0,-7,-8,-8,-8,-8,-8,-8,-8,-8,-8,-8,-8,-7,-5,-2,0,0,0,0,0};
   // Released jump, both strobes each cycle.
   int t1p[16]  = '{-7,-13,-18,-22,-25,-27,-28,-28,-27,-25,-22,-18,-13,-7,-1,0};
   int t1v[16]  = '{-6,-5,-4,-3,-2,-1,0,1,2,3,4,5,6,6,6,0};

   initial begin
      rst = 1'b1; rst4 = 1'b1;
      vel_tick = 1'b0; pos_tick = 1'b0; jump_btn = 1'b0; down_btn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pos", int'(position), 0);
      chk("rst_vel", int'(velocity), 0);
      chk("rst_st", int'(state), G);
      chk("rst_duck", int'(duck), 0);
      chk("rst_pos4", int'(position4), 0);
      rst = 1'b0;
      step("idle_vt", 1, 0, 0, 0, 0, 0, G, 0);
      step("idle_pt", 0, 1, 0, 0, 0, 0, G, 0);

      // Ground jump released immediately.
      step("t1_edge", 0, 0, 1, 0, 0, 0, G, 0);
      step("t1_load", 1, 0, 0, 0, 0, -7, R, 0);
      for (int i = 0; i < 16; i++)
         step($sformatf("t1_c%0d", i + 1), 1, 1, 0, 0, t1p[i], t1v[i],
              (i < 6) ? R : ((i < 15) ? F : G), (i == 15) ? 1 : 0);
      step("t1_after", 0, 0, 0, 0, 0, 0, G, 0);
      step("t1_gnd_pt", 0, 1, 0, 0, 0, 0, G, 0);

      // Held jump; POS_W=4 copy runs alongside to show position clamping.
      rst4 = 1'b0;
      step("t2_arm", 0, 0, 0, 0, 0, 0, G, 0);
      step("t2_edge", 0, 0, 1, 0, 0, 0, G, 0);
      for (int i = 0; i < 21; i++) begin
         step($sformatf("t2_c%0d", i), 1, 1, (i <= 9), 0, t2p[i], t2v[i],
              (i <= 10) ? R : ((i < 20) ? F : G), (i == 20) ? 1 : 0);
         chk($sformatf("t4_pos_c%0d", i), int'(position4), t2p4[i]);
         chk($sformatf("t4_st_c%0d", i), int'(state4), (i <= 10) ? R : ((i < 16) ? F : G));
      end
      rst4 = 1'b1;
      step("t2_after", 0, 0, 0, 0, 0, 0, G, 0);

      // Fast drop from FALL at -15.
      step("t3_edge", 0, 0, 1, 0, 0, 0, G, 0);
      step("t3_load", 1, 0, 0, 0, 0, -7, R, 0);
      step("t3_p1", 0, 1, 0, 0, -7, -7, R, 0);
      step("t3_v1", 1, 0, 0, 0, -7, -6, R, 0);
      step("t3_p2", 0, 1, 0, 0, -13, -6, R, 0);
      for (int k = 1; k <= 4; k++)
         step($sformatf("t3_v%0d", k + 1), 1, 0, 0, 0, -13, -6 + k, R, 0);
      step("t3_p3", 0, 1, 0, 0, -15, -2, R, 0);
      step("t3_v6", 1, 0, 0, 0, -15, -1, R, 0);
      step("t3_v7", 1, 0, 0, 0, -15, 0, F, 0);
      step("t3_fd", 1, 0, 0, 1, -15, 6, D, 0);
      step("t3_fp1", 0, 1, 0, 0, -9, 6, D, 0);
      step("t3_sticky", 1, 0, 0, 0, -9, 6, D, 0);
      step("t3_fp2", 0, 1, 0, 0, -3, 6, D, 0);
      step("t3_land", 0, 1, 0, 0, 0, 0, G, 1);
      step("t3_down", 0, 0, 0, 1, 0, 0, G, 0);
      chk("t3_duck_on", int'(duck), 1);
      step("t3_dn_edge", 0, 0, 1, 1, 0, 0, G, 0);
      step("t3_dn_vt", 1, 0, 1, 1, 0, 0, G, 0);
      step("t3_up_vt", 1, 0, 0, 0, 0, 0, G, 0);
      chk("t3_duck_off", int'(duck), 0);

      // Async reset in the middle of a rise, between clock edges.
      step("t5_edge", 0, 0, 1, 0, 0, 0, G, 0);
      step("t5_load", 1, 0, 0, 0, 0, -7, R, 0);
      step("t5_p1", 0, 1, 0, 0, -7, -7, R, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_pos", int'(position), 0);
      chk("t5_vel", int'(velocity), 0);
      chk("t5_st", int'(state), G);
      chk("t5_lp", int'(land_pulse), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      step("t5_post", 1, 1, 0, 0, 0, 0, G, 0);

`ifdef DOUBLE_JUMP_EN
      step("t6_edge", 0, 0, 1, 0, 0, 0, G, 0);
      step("t6_load", 1, 0, 0, 0, 0, -7, R, 0);
      step("t6_p1", 0, 1, 0, 0, -7, -7, R, 0);
      for (int k = 1; k <= 7; k++)
         step($sformatf("t6_a%0d", k), 1, 0, 0, 0, -7, -7 + k, (k == 7) ? F : R, 0);
      step("t6_dj_edge", 0, 0, 1, 0, -7, 0, F, 0);
      step("t6_dj_load", 1, 0, 0, 0, -7, -7, R, 0);
      step("t6_p2", 0, 1, 0, 0, -14, -7, R, 0);
      for (int k = 1; k <= 7; k++)
         step($sformatf("t6_b%0d", k), 1, 0, 0, 0, -14, -7 + k, (k == 7) ? F : R, 0);
      step("t6_3rd_edge", 0, 0, 1, 0, -14, 0, F, 0);
      step("t6_3rd_vt", 1, 0, 0, 0, -14, 1, F, 0);
      step("t6_c1", 1, 1, 0, 0, -13, 2, F, 0);
      step("t6_c2", 1, 1, 0, 0, -11, 3, F, 0);
      step("t6_c3", 1, 1, 0, 0, -8, 4, F, 0);
      step("t6_c4", 1, 1, 0, 0, -4, 5, F, 0);
      step("t6_land", 1, 1, 0, 0, 0, 0, G, 1);
      step("t6_re_edge", 0, 0, 1, 0, 0, 0, G, 0);
      step("t6_re_load", 1, 0, 0, 0, 0, -7, R, 0);
      step("t6_re_p", 0, 1, 0, 0, -7, -7, R, 0);
      for (int k = 1; k <= 7; k++)
         step($sformatf("t6_d%0d", k), 1, 0, 0, 0, -7, -7 + k, (k == 7) ? F : R, 0);
      step("t6_rearm_edge", 0, 0, 1, 0, -7, 0, F, 0);
      step("t6_rearm_load", 1, 0, 0, 0, -7, -7, R, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
